// File: rtl/stage_mem_pkg.sv
// Shared types and constants for the lookup-stage table RAM port-B sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stage_mem_pkg;

   // Default geometry of one stage table.
   localparam int unsigned DATA_W_DEF = 72;
   localparam int unsigned ADDR_W_DEF = 10;

   // Command type carried on upd_rd.
   localparam logic CMD_WR = 1'b0;
   localparam logic CMD_RD = 1'b1;

   // Sequencer states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CLEAR   = 2'd1,
      RD_WAIT = 2'd2,
      RSP     = 2'd3
   } state_e;

   // Saturating 32-bit increment for the statistics counters.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/bram_tdp.sv
// True dual-port table RAM, both ports on one clock, read-first on each port.
// Latency: 1 cycle from address to dout on either port.
// Backpressure: none; every port accepts an access every cycle.
module bram_tdp #(
   parameter int unsigned DATA = 72,
   parameter int unsigned ADDR = 10
)(
   input  logic              clk,
   input  logic              a_wr,
   input  logic [ADDR-1:0]   a_addr,
   input  logic [DATA-1:0]   a_din,
   output logic [DATA-1:0]   a_dout,
   input  logic              b_wr,
   input  logic [ADDR-1:0]   b_addr,
   input  logic [DATA-1:0]   b_din,
   output logic [DATA-1:0]   b_dout
);

   logic [DATA-1:0] r_mem [0:(1<<ADDR)-1];
   logic [DATA-1:0] r_a_dout;
   logic [DATA-1:0] r_b_dout;

   // Both ports share one process so the array has a single writer; port B wins a same-address collision.
   always_ff @(posedge clk) begin
      r_a_dout <= r_mem[a_addr];
      r_b_dout <= r_mem[b_addr];
      if (a_wr) r_mem[a_addr] <= a_din;
      if (b_wr) r_mem[b_addr] <= b_din;
   end

   assign a_dout = r_a_dout;
   assign b_dout = r_b_dout;

endmodule

// File: rtl/stage_mem_ctrl.sv
// Port-B sequencer for one stage table: host writes/read-backs plus a whole-table clear; STAGE_MEM_CTRL_STATS_EN adds command counters.
// Latency: write issued in the accept cycle; read data valid 2 cycles after accept; clear takes 2**ADDR cycles, done pulse 1 cycle later.
// Backpressure: upd_ready low outside IDLE and while clr_start is high; read response held until rsp_ready.
module stage_mem_ctrl
   import stage_mem_pkg::*;
#(
   parameter int unsigned     STAGE_ID    = 0,
   parameter int unsigned     DATA        = DATA_W_DEF,
   parameter int unsigned     ADDR        = ADDR_W_DEF,
   parameter logic [DATA-1:0] CLEAR_VALUE = {DATA{1'b0}}
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              upd_valid,
   output logic              upd_ready,
   input  logic              upd_rd,
   input  logic [ADDR-1:0]   upd_addr,
   input  logic [DATA-1:0]   upd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA-1:0]   rsp_data,
   input  logic              clr_start,
   output logic              clr_done,
   output logic              busy,
   output logic              mem_wr,
   output logic [ADDR-1:0]   mem_addr,
   output logic [DATA-1:0]   mem_din,
   input  logic [DATA-1:0]   mem_dout
`ifdef STAGE_MEM_CTRL_STATS_EN
   ,
   output logic [31:0]       stat_wr_cnt,
   output logic [31:0]       stat_rd_cnt
`endif
);

   // Counter value of the final clear write; the extra MSB keeps the walk from wrapping.
   localparam logic [ADDR:0] LAST_ADDR = {1'b0, {ADDR{1'b1}}};

   state_e          r_state;
   state_e          w_state_nxt;
   logic [ADDR:0]   r_clr_cnt;
   logic [DATA-1:0] r_rsp_data;
   logic            r_clr_done;

   logic            w_idle;
   logic            w_upd_rdy;
   logic            w_acc;
   logic            w_acc_wr;
   logic            w_acc_rd;
   logic            w_clr_go;
   logic            w_clr_last;

   // A clear request in IDLE takes precedence and blocks any command that cycle.
   assign w_idle     = (r_state == IDLE);
   assign w_upd_rdy  = w_idle & ~clr_start;
   assign w_acc      = upd_valid & w_upd_rdy;
   assign w_acc_wr   = w_acc & (upd_rd == CMD_WR);
   assign w_acc_rd   = w_acc & (upd_rd == CMD_RD);
   assign w_clr_go   = w_idle & clr_start;
   assign w_clr_last = (r_state == CLEAR) && (r_clr_cnt == LAST_ADDR);

   // Next-state selection; writes never leave IDLE so they stream at one per cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (clr_start)     w_state_nxt = CLEAR;
            else if (w_acc_rd) w_state_nxt = RD_WAIT;
         end
         CLEAR: begin
            if (w_clr_last) w_state_nxt = IDLE;
         end
         RD_WAIT: w_state_nxt = RSP;
         RSP: begin
            if (rsp_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register; reset aborts any clear walk or pending read outright.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Clear address walk: restarts at zero on each accepted clear request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_clr_cnt <= '0;
      else if (w_clr_go)          r_clr_cnt <= '0;
      else if (r_state == CLEAR)  r_clr_cnt <= r_clr_cnt + (ADDR+1)'(1);
   end

   // Done pulse lands in the first IDLE cycle after the last clear write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_clr_done <= 1'b0;
      else        r_clr_done <= w_clr_last;
   end

   // Capture RAM read data once; it then stays stable for the whole response phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  r_rsp_data <= '0;
      else if (r_state == RD_WAIT) r_rsp_data <= mem_dout;
   end

   // Port-B drive: clear writes, or the command accepted this cycle; idle otherwise.
   always_comb begin
      mem_wr   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      if (r_state == CLEAR) begin
         mem_wr   = 1'b1;
         mem_addr = r_clr_cnt[ADDR-1:0];
         mem_din  = CLEAR_VALUE;
      end else if (w_acc) begin
         mem_wr   = w_acc_wr;
         mem_addr = upd_addr;
         if (w_acc_wr) mem_din = upd_data;
      end
   end

   // Guard: a port-B write must never overlap an outstanding read-back.
   always_comb begin
      assert (!(mem_wr && ((r_state == RD_WAIT) || (r_state == RSP))))
         else $error("stage_mem_ctrl[%0d]: port B write during read-back", STAGE_ID);
   end

   assign upd_ready = w_upd_rdy;
   assign rsp_valid = (r_state == RSP);
   assign rsp_data  = r_rsp_data;
   assign clr_done  = r_clr_done;
   assign busy      = ~w_idle;

`ifdef STAGE_MEM_CTRL_STATS_EN
   logic [31:0] r_stat_wr;
   logic [31:0] r_stat_rd;

   // Saturating command counters, zeroed by an accepted clear; clear writes are not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_wr <= '0;
         r_stat_rd <= '0;
      end else if (w_clr_go) begin
         r_stat_wr <= '0;
         r_stat_rd <= '0;
      end else begin
         if (w_acc_wr) r_stat_wr <= sat_inc(r_stat_wr);
         if (w_acc_rd) r_stat_rd <= sat_inc(r_stat_rd);
      end
   end

   assign stat_wr_cnt = r_stat_wr;
   assign stat_rd_cnt = r_stat_rd;
`endif

endmodule

// File: tb/tb_stage_mem_ctrl.sv
// Bench for stage_mem_ctrl driving a bram_tdp, with port A read by a lookup model.
// Latency: directed vectors, outputs sampled mid-cycle against a transaction-level model.
// Backpressure: exercises rsp_ready low, clr_start collisions and reset mid-clear.
module tb_stage_mem_ctrl;
   import stage_mem_pkg::*;

   localparam int unsigned   DW    = 72;
   localparam int unsigned   AW    = 4;
   localparam int            DEPTH = 16;
   localparam logic [DW-1:0] CV    = 72'h0000_0000_0000_0000_CC;

   logic          clk;
   logic          rst_n;
   logic          upd_valid, upd_ready, upd_rd;
   logic [AW-1:0] upd_addr;
   logic [DW-1:0] upd_data;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          clr_start, clr_done, busy;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din, mem_dout;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_dout;
`ifdef STAGE_MEM_CTRL_STATS_EN
   logic [31:0]   stat_wr_cnt, stat_rd_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   stage_mem_ctrl #(.STAGE_ID(3), .DATA(DW), .ADDR(AW), .CLEAR_VALUE(CV)) dut (
      .clk(clk), .rst_n(rst_n),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_rd(upd_rd),
      .upd_addr(upd_addr), .upd_data(upd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .clr_start(clr_start), .clr_done(clr_done), .busy(busy),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef STAGE_MEM_CTRL_STATS_EN
      , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt)
`endif
   );

   bram_tdp #(.DATA(DW), .ADDR(AW)) ram (
      .clk(clk),
      .a_wr(1'b0), .a_addr(a_addr), .a_din('0), .a_dout(a_dout),
      .b_wr(mem_wr), .b_addr(mem_addr), .b_din(mem_din), .b_dout(mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- transaction-level model ----------------
   // Table contents, remaining clear writes, and a read in flight (phase 0 = waiting on RAM, 1 = offered).
   logic [DW-1:0] m_mem [DEPTH];
   int            m_clr_left = 0;
   int            m_clr_next = 0;
   int            m_rd_phase = -1;
   logic [DW-1:0] m_rd_word  = '0;
   logic          m_done     = 1'b0;
   logic [31:0]   m_wr_cnt   = '0;
   logic [31:0]   m_rd_cnt   = '0;
   logic          e_idle, e_acc;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_clr_left = 0;
         m_rd_phase = -1;
         m_done     = 1'b0;
         m_wr_cnt   = '0;
         m_rd_cnt   = '0;
      end
      e_idle = (m_clr_left == 0) && (m_rd_phase < 0);
      e_acc  = e_idle && !clr_start && upd_valid;

      chk("cyc_upd_ready", upd_ready, e_idle && !clr_start);
      chk("cyc_busy", busy, !e_idle);
      chk("cyc_rsp_valid", rsp_valid, m_rd_phase == 1);
      if (m_rd_phase == 1) chk("cyc_rsp_data", rsp_data, m_rd_word);
      if (!rst_n) chk("cyc_rst_rsp_data", rsp_data, '0);
      chk("cyc_clr_done", clr_done, m_done);
      if (m_clr_left > 0) begin
         chk("cyc_clr_wr", mem_wr, 1'b1);
         chk("cyc_clr_addr", mem_addr, m_clr_next);
         chk("cyc_clr_din", mem_din, CV);
      end else if (e_acc && !upd_rd) begin
         chk("cyc_wr", mem_wr, 1'b1);
         chk("cyc_wr_addr", mem_addr, upd_addr);
         chk("cyc_wr_din", mem_din, upd_data);
      end else begin
         chk("cyc_nowr", mem_wr, 1'b0);
         chk("cyc_addr", mem_addr, e_acc ? upd_addr : '0);
      end
`ifdef STAGE_MEM_CTRL_STATS_EN
      chk("cyc_stat_wr", stat_wr_cnt, m_wr_cnt);
      chk("cyc_stat_rd", stat_rd_cnt, m_rd_cnt);
`endif

      if (rst_n) begin
         m_done = 1'b0;
         if (m_clr_left > 0) begin
            m_mem[m_clr_next] = CV;
            m_clr_next++;
            m_clr_left--;
            if (m_clr_left == 0) m_done = 1'b1;
         end else if (m_rd_phase == 0) begin
            m_rd_phase = 1;
         end else if (m_rd_phase == 1) begin
            if (rsp_ready) m_rd_phase = -1;
         end else if (clr_start) begin
            m_clr_left = DEPTH;
            m_clr_next = 0;
            m_wr_cnt   = '0;
            m_rd_cnt   = '0;
         end else if (e_acc) begin
            if (upd_rd) begin
               m_rd_phase = 0;
               m_rd_word  = m_mem[upd_addr];
               if (m_rd_cnt != 32'hFFFF_FFFF) m_rd_cnt = m_rd_cnt + 32'd1;
            end else begin
               m_mem[upd_addr] = upd_data;
               if (m_wr_cnt != 32'hFFFF_FFFF) m_wr_cnt = m_wr_cnt + 32'd1;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic pa_check(input int addr, input logic [DW-1:0] exp, input string name);
      a_addr = AW'(addr);
      step();
      chk(name, a_dout, exp);
      chk({name, "_model"}, a_dout, m_mem[addr]);
   endtask

   task automatic fill(input logic [DW-1:0] base);
      for (int i = 0; i < DEPTH; i++) begin
         upd_valid = 1'b1; upd_rd = 1'b0; upd_addr = AW'(i); upd_data = base + DW'(i);
         step();
      end
      upd_valid = 1'b0;
      step();
   endtask

   task automatic do_write(input int addr, input logic [DW-1:0] data);
      upd_valid = 1'b1; upd_rd = 1'b0; upd_addr = AW'(addr); upd_data = data;
      step();
      upd_valid = 1'b0;
   endtask

   task automatic do_read(input int addr, input logic [DW-1:0] exp, input string name);
      int n;
      rsp_ready = 1'b1; upd_valid = 1'b1; upd_rd = 1'b1; upd_addr = AW'(addr);
      step();
      upd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 10) begin
         step();
         n++;
      end
      chk({name, "_seen"}, rsp_valid, 1'b1);
      chk({name, "_data"}, rsp_data, exp);
      step();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int lat;
      int pulses;
      bit found;
      upd_valid = 1'b0; upd_rd = 1'b0; upd_addr = '0; upd_data = '0;
      rsp_ready = 1'b1; clr_start = 1'b0; a_addr = '0; rst_n = 1'b0;
      repeat (2) step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_data", rsp_data, '0);
      chk("rst_clr_done", clr_done, 1'b0);
      rst_n = 1'b1;
      step();

      fill(72'h100);

      // Back-to-back writes to 5 and 6.
      upd_valid = 1'b1; upd_rd = 1'b0; upd_addr = 4'd5; upd_data = 72'h0AA;
      #1 chk("wr5_mem_wr", mem_wr, 1'b1); chk("wr5_ready", upd_ready, 1'b1);
      step();
      upd_addr = 4'd6; upd_data = 72'h0BB;
      #1 chk("wr6_mem_wr", mem_wr, 1'b1); chk("wr6_ready", upd_ready, 1'b1);
      step();
      upd_valid = 1'b0;
      pa_check(5, 72'h0AA, "pa_addr5");
      pa_check(6, 72'h0BB, "pa_addr6");

      // Read 5 with rsp_ready high.
      rsp_ready = 1'b1; upd_valid = 1'b1; upd_rd = 1'b1; upd_addr = 4'd5;
      #1 chk("rd5_accept", upd_ready, 1'b1);
      step();
      upd_valid = 1'b0;
      chk("rd5_T1_valid", rsp_valid, 1'b0); chk("rd5_T1_ready", upd_ready, 1'b0);
      step();
      chk("rd5_T2_valid", rsp_valid, 1'b1); chk("rd5_T2_data", rsp_data, 72'h0AA);
      chk("rd5_T2_ready", upd_ready, 1'b0);
      step();
      chk("rd5_T3_valid", rsp_valid, 1'b0); chk("rd5_T3_ready", upd_ready, 1'b1);

      // Read 6 with the consumer stalling for 4 cycles.
      rsp_ready = 1'b0; upd_valid = 1'b1; upd_rd = 1'b1; upd_addr = 4'd6;
      step();
      upd_valid = 1'b0;
      step();
      for (int k = 0; k < 4; k++) begin
         chk("rd6_hold_valid", rsp_valid, 1'b1);
         chk("rd6_hold_data", rsp_data, 72'h0BB);
         chk("rd6_hold_ready", upd_ready, 1'b0);
         step();
      end
      rsp_ready = 1'b1;
      chk("rd6_hs_valid", rsp_valid, 1'b1);
      step();
      chk("rd6_idle_ready", upd_ready, 1'b1);
      chk("rd6_idle_busy", busy, 1'b0);

      // Clear colliding with a write to 7.
      clr_start = 1'b1; upd_valid = 1'b1; upd_rd = 1'b0; upd_addr = 4'd7; upd_data = 72'h777;
      #1 chk("clr_collide_ready", upd_ready, 1'b0); chk("clr_collide_wr", mem_wr, 1'b0);
      step();
      clr_start = 1'b0; upd_valid = 1'b0;
      lat = 1; found = 1'b0;
      while (!found && lat <= 40) begin
         if (clr_done) found = 1'b1;
         else begin
            step();
            lat++;
         end
      end
      chk("clr_done_latency", lat, 17);
      chk("clr_done_busy", busy, 1'b0);
      step();
      chk("clr_done_single", clr_done, 1'b0);
      for (int i = 0; i < DEPTH; i++) pa_check(i, CV, "pa_cleared");

      // Reset in the middle of a clear walk.
      fill(72'h200);
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      repeat (8) step();
      chk("mid_clr_addr", mem_addr, 4'd8);
      chk("mid_clr_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1 chk("rst_mid_busy", busy, 1'b0); chk("rst_mid_wr", mem_wr, 1'b0);
      step();
      step();
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         if (clr_done) pulses++;
         step();
      end
      chk("rst_no_clr_done", pulses, 0);
      for (int i = 0; i < 8; i++) pa_check(i, CV, "pa_rst_cleared");
      for (int i = 8; i < DEPTH; i++) pa_check(i, 72'h200 + DW'(i), "pa_rst_kept");

      // Command counting: 3 writes, 2 reads, then a clear.
      do_write(1, 72'h11);
      do_write(2, 72'h22);
      do_write(3, 72'h33);
      do_read(1, 72'h11, "cnt_rd1");
      do_read(2, 72'h22, "cnt_rd2");
`ifdef STAGE_MEM_CTRL_STATS_EN
      chk("stat_wr_3", stat_wr_cnt, 32'd3);
      chk("stat_rd_2", stat_rd_cnt, 32'd2);
`endif
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
`ifdef STAGE_MEM_CTRL_STATS_EN
      chk("stat_wr_clr", stat_wr_cnt, 32'd0);
      chk("stat_rd_clr", stat_rd_cnt, 32'd0);
`endif
      lat = 1;
      while (!clr_done && lat <= 40) begin
         step();
         lat++;
      end
      chk("clr2_done_latency", lat, 17);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

endmodule
